// File: rtl/xbar_rr_sched.sv
// Per-output round-robin scheduler for the packet crossbar: each output port locks
// onto one source queue from sop to eop, with a watchdog that frees stalled locks.
module xbar_rr_sched #(
    parameter int NUM_QUEUES = 16,
    parameter int SEL_W      = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_QUEUES-1:0]       in_valid,
    input  logic [NUM_QUEUES-1:0]       in_sop,
    input  logic [NUM_QUEUES-1:0]       in_eop,
    input  logic [NUM_QUEUES*SEL_W-1:0] in_dest,
    output logic [NUM_QUEUES-1:0]       in_ready,
    output logic [NUM_QUEUES*SEL_W-1:0] out_sel,
    output logic [NUM_QUEUES-1:0]       out_wr,
    output logic [NUM_QUEUES-1:0]       out_busy,
    output logic [NUM_QUEUES-1:0]       err_timeout,
    output logic [NUM_QUEUES*SEL_W-1:0] dbg_rr_ptr
);
    // Handshake: a head word moves when in_valid[i] & in_ready[i]; in_ready never waits on in_valid.
    localparam int WD_W = $clog2(TIMEOUT);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                          state  [NUM_QUEUES];
    logic [SEL_W-1:0]                owner  [NUM_QUEUES];
    logic [SEL_W-1:0]                rr_ptr [NUM_QUEUES];
    logic [WD_W-1:0]                 wd_cnt [NUM_QUEUES];
    logic [NUM_QUEUES-1:0]           owned;
    logic [NUM_QUEUES-1:0][NUM_QUEUES-1:0] req;
    logic [NUM_QUEUES-1:0]           gnt_valid;
    logic [SEL_W-1:0]                gnt_idx [NUM_QUEUES];

    always_comb begin
        owned = '0;
        for (int o = 0; o < NUM_QUEUES; o++) begin
            if (state[o] == LOCKED) owned[owner[o]] = 1'b1;
        end
    end

    // A queue already owned by some port must not start a second lock.
    always_comb begin
        req = '0;
        for (int o = 0; o < NUM_QUEUES; o++) begin
            for (int i = 0; i < NUM_QUEUES; i++) begin
                req[o][i] = in_valid[i] & in_sop[i] & ~owned[i] &
                            (in_dest[i*SEL_W +: SEL_W] == SEL_W'(o));
            end
        end
    end

    // Scan downwards so the candidate closest to rr_ptr is the last one written.
    always_comb begin
        for (int o = 0; o < NUM_QUEUES; o++) begin
            gnt_valid[o] = 1'b0;
            gnt_idx[o]   = '0;
            for (int k = NUM_QUEUES - 1; k >= 0; k--) begin
                if (req[o][rr_ptr[o] + SEL_W'(k)]) begin
                    gnt_valid[o] = 1'b1;
                    gnt_idx[o]   = rr_ptr[o] + SEL_W'(k);
                end
            end
        end
    end

    always_comb begin
        in_ready   = owned;
        out_wr     = '0;
        out_busy   = '0;
        out_sel    = '0;
        dbg_rr_ptr = '0;
        for (int o = 0; o < NUM_QUEUES; o++) begin
            out_wr[o]                     = (state[o] == LOCKED) & in_valid[owner[o]];
            out_busy[o]                   = (state[o] == LOCKED);
            out_sel[o*SEL_W +: SEL_W]     = owner[o];
            dbg_rr_ptr[o*SEL_W +: SEL_W]  = rr_ptr[o];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int o = 0; o < NUM_QUEUES; o++) begin
                state[o]  <= IDLE;
                owner[o]  <= '0;
                rr_ptr[o] <= '0;
                wd_cnt[o] <= '0;
            end
            err_timeout <= '0;
        end else begin
            for (int o = 0; o < NUM_QUEUES; o++) begin
                case (state[o])
                    IDLE: begin
                        if (gnt_valid[o]) begin
                            state[o]  <= LOCKED;
                            owner[o]  <= gnt_idx[o];
                            wd_cnt[o] <= '0;
                        end
                    end
                    LOCKED: begin
                        if (in_valid[owner[o]]) begin
                            wd_cnt[o] <= '0;
                            if (in_eop[owner[o]]) begin
                                state[o]  <= IDLE;
                                rr_ptr[o] <= owner[o] + 1'b1;
                            end
                        end else if (wd_cnt[o] == WD_W'(TIMEOUT - 1)) begin
                            // Source went silent mid-packet: drop the lock and flag it.
                            state[o]       <= IDLE;
                            rr_ptr[o]      <= owner[o] + 1'b1;
                            wd_cnt[o]      <= '0;
                            err_timeout[o] <= 1'b1;
                        end else begin
                            wd_cnt[o] <= wd_cnt[o] + 1'b1;
                        end
                    end
                    default: state[o] <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_xbar_rr_sched.sv
// Directed bench for xbar_rr_sched: per-queue packet sources, a packet-level
// scheduler model compared every cycle, and literal checks on the directed scenarios.
module tb_xbar_rr_sched;
    localparam int NQ = 16;
    localparam int SW = 4;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NQ-1:0]     in_valid = '0;
    logic [NQ-1:0]     in_sop = '0;
    logic [NQ-1:0]     in_eop = '0;
    logic [NQ*SW-1:0]  in_dest = '0;
    logic [NQ-1:0]     in_ready;
    logic [NQ*SW-1:0]  out_sel;
    logic [NQ-1:0]     out_wr;
    logic [NQ-1:0]     out_busy;
    logic [NQ-1:0]     err_timeout;
    logic [NQ*SW-1:0]  dbg_rr_ptr;

    xbar_rr_sched #(.NUM_QUEUES(NQ), .SEL_W(SW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop), .in_dest(in_dest),
        .in_ready(in_ready), .out_sel(out_sel), .out_wr(out_wr),
        .out_busy(out_busy), .err_timeout(err_timeout), .dbg_rr_ptr(dbg_rr_ptr)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    typedef struct packed {
        logic [SW-1:0] dest;
        logic          sop;
        logic          eop;
    } word_t;

    word_t qw [NQ][$];
    bit    stall [NQ];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;

    // packet-level model of each output port
    int m_locked [NQ];
    int m_owner  [NQ];
    int m_rr     [NQ];
    int m_idle   [NQ];
    bit m_err    [NQ];

    // observation logs for the directed checks
    int g_port[$];
    int g_src[$];
    int g_cyc[$];
    int f_port[$];
    int f_cyc[$];
    int wr_cnt [NQ];
    int both_wr = 0;
    logic [NQ-1:0] prev_busy = '0;
    logic [SW-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [NQ-1:0] m_ready();
        logic [NQ-1:0] r;
        r = '0;
        for (int o = 0; o < NQ; o++) if (m_locked[o] != 0) r[m_owner[o]] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        for (int o = 0; o < NQ; o++) begin
            m_locked[o] = 0; m_owner[o] = 0; m_rr[o] = 0; m_idle[o] = 0; m_err[o] = 0;
        end
    endtask

    task automatic model_step();
        logic [NQ-1:0] own;
        int s;
        int i;
        bit found;
        own = m_ready();
        for (int q = 0; q < NQ; q++) if (in_valid[q] && own[q]) void'(qw[q].pop_front());
        for (int o = 0; o < NQ; o++) begin
            if (m_locked[o] != 0) begin
                s = m_owner[o];
                if (in_valid[s]) begin
                    m_idle[o] = 0;
                    if (in_eop[s]) begin
                        m_locked[o] = 0; m_rr[o] = (s + 1) % NQ;
                    end
                end else begin
                    m_idle[o]++;
                    if (m_idle[o] == TO) begin
                        m_locked[o] = 0; m_rr[o] = (s + 1) % NQ; m_idle[o] = 0; m_err[o] = 1;
                    end
                end
            end else begin
                found = 0;
                for (int k = 0; k < NQ; k++) begin
                    i = (m_rr[o] + k) % NQ;
                    if (!found && in_valid[i] && in_sop[i] && !own[i] &&
                        int'(in_dest[i*SW +: SW]) == o) begin
                        found = 1; m_locked[o] = 1; m_owner[o] = i; m_idle[o] = 0;
                    end
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_inputs();
        logic [NQ-1:0]    v, s, e;
        logic [NQ*SW-1:0] d;
        v = '0; s = '0; e = '0; d = '0;
        for (int q = 0; q < NQ; q++) begin
            if (qw[q].size() > 0 && !stall[q]) begin
                v[q] = 1'b1;
                s[q] = qw[q][0].sop;
                e[q] = qw[q][0].eop;
                d[q*SW +: SW] = qw[q][0].dest;
            end
        end
        in_valid = v; in_sop = s; in_eop = e; in_dest = d;
    endtask

    task automatic push_pkt(input int q, input int dest, input int len);
        word_t w;
        for (int b = 0; b < len; b++) begin
            w.dest = SW'(dest);
            w.sop  = (b == 0);
            w.eop  = (b == len - 1);
            qw[q].push_back(w);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        g_port.delete(); g_src.delete(); g_cyc.delete();
        f_port.delete(); f_cyc.delete(); exp_q.delete();
        for (int o = 0; o < NQ; o++) wr_cnt[o] = 0;
        both_wr = 0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        bit busy;
        n = 0;
        do begin
            sync();
            n++;
            busy = 0;
            for (int q = 0; q < NQ; q++) if (!stall[q] && qw[q].size() > 0) busy = 1;
            for (int o = 0; o < NQ; o++) if (m_locked[o] != 0) busy = 1;
        end while (busy && n < budget);
        check("drain", 64'(busy), 64'd0);
        sync();
        sync();
    endtask

    // model advance and input refresh around each rising edge
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) model_step();
            #1;
            drive_inputs();
        end
    end

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin
        logic [NQ-1:0]    e_wr, e_busy, e_err;
        logic [NQ*SW-1:0] e_sel, e_rr;
        e_wr = '0; e_busy = '0; e_err = '0; e_sel = '0; e_rr = '0;
        for (int o = 0; o < NQ; o++) begin
            e_busy[o] = (m_locked[o] != 0);
            e_wr[o]   = (m_locked[o] != 0) && in_valid[m_owner[o]];
            e_err[o]  = m_err[o];
            e_sel[o*SW +: SW] = SW'(m_owner[o]);
            e_rr[o*SW +: SW]  = SW'(m_rr[o]);
        end
        check("in_ready", 64'(in_ready), 64'(m_ready()));
        check("out_wr", 64'(out_wr), 64'(e_wr));
        check("out_busy", 64'(out_busy), 64'(e_busy));
        check("err_timeout", 64'(err_timeout), 64'(e_err));
        check("out_sel", out_sel, e_sel);
        check("rr_ptr", dbg_rr_ptr, e_rr);
        for (int o = 0; o < NQ; o++) begin
            if (out_busy[o] && !prev_busy[o]) begin
                g_port.push_back(o); g_src.push_back(int'(out_sel[o*SW +: SW])); g_cyc.push_back(cyc);
            end
            if (!out_busy[o] && prev_busy[o]) begin
                f_port.push_back(o); f_cyc.push_back(cyc);
            end
            if (out_wr[o]) wr_cnt[o]++;
        end
        if (out_wr[0] && out_wr[1]) both_wr++;
        prev_busy = out_busy;
    end

    // ---------------- directed sequence ----------------
    initial begin
        int t0;
        #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        #1;
        check("reset_ready", 64'(in_ready), 64'd0);
        check("reset_sel", out_sel, 64'd0);
        check("reset_busy", 64'(out_busy), 64'd0);
        check("reset_err", 64'(err_timeout), 64'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;

        // single 4-beat packet, queue 3 -> port 5
        clear_logs();
        sync(); t0 = cyc;
        push_pkt(3, 5, 4); drive_inputs();
        wait_done(100);
        check("single_grants", g_src.size(), 1);
        check("single_src", (g_src.size() > 0) ? g_src[0] : -1, 3);
        check("single_port", (g_port.size() > 0) ? g_port[0] : -1, 5);
        check("single_lat", (g_cyc.size() > 0) ? g_cyc[0] - t0 : -1, 1);
        check("single_wr_beats", wr_cnt[5], 4);
        check("single_busy_drop", (f_cyc.size() > 0) ? f_cyc[0] - t0 : -1, 5);
        check("single_rr", dbg_rr_ptr[5*SW +: SW], 4);

        // round-robin among queues 0, 7, 15 onto port 2
        clear_logs();
        sync(); t0 = cyc;
        for (int p = 0; p < 2; p++) begin
            push_pkt(0, 2, 2); push_pkt(7, 2, 2); push_pkt(15, 2, 2);
        end
        drive_inputs();
        wait_done(200);
        exp_q = '{4'd0, 4'd7, 4'd15, 4'd0, 4'd7, 4'd15};
        check("rr_grants", g_src.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < g_src.size(); k++)
            check("rr_order", g_src[k], exp_q[k]);
        check("rr_first_lat", (g_cyc.size() > 0) ? g_cyc[0] - t0 : -1, 1);
        for (int k = 0; k + 1 < g_cyc.size(); k++)
            check("rr_spacing", g_cyc[k+1] - g_cyc[k], 3);

        // wrap: single-word packet moves rr_ptr[9] to 15, then 15 beats 1
        clear_logs();
        sync();
        push_pkt(14, 9, 1); drive_inputs();
        wait_done(50);
        check("sw_hold", (g_cyc.size() > 0 && f_cyc.size() > 0) ? f_cyc[0] - g_cyc[0] : -1, 1);
        check("wrap_rr_setup", dbg_rr_ptr[9*SW +: SW], 15);
        clear_logs();
        sync();
        push_pkt(15, 9, 2); push_pkt(1, 9, 2); drive_inputs();
        wait_done(50);
        exp_q = '{4'd15, 4'd1};
        check("wrap_grants", g_src.size(), 2);
        for (int k = 0; k < exp_q.size() && k < g_src.size(); k++)
            check("wrap_order", g_src[k], exp_q[k]);
        check("wrap_rr_after", dbg_rr_ptr[9*SW +: SW], 2);

        // parallel: queue 0 -> port 1 and queue 1 -> port 0
        clear_logs();
        sync(); t0 = cyc;
        push_pkt(0, 1, 3); push_pkt(1, 0, 3); drive_inputs();
        wait_done(50);
        check("par_grants", g_src.size(), 2);
        check("par_cyc0", (g_cyc.size() > 0) ? g_cyc[0] - t0 : -1, 1);
        check("par_cyc1", (g_cyc.size() > 1) ? g_cyc[1] - t0 : -1, 1);
        check("par_both_wr", both_wr, 3);

        // watchdog: queue 4 stalls after its sop on port 6, queue 5 waits behind it
        clear_logs();
        sync(); t0 = cyc;
        push_pkt(4, 6, 3); push_pkt(5, 6, 2); drive_inputs();
        sync();
        sync();
        stall[4] = 1; drive_inputs();
        wait_done(100);
        check("wd_grants", g_src.size(), 2);
        check("wd_src0", (g_src.size() > 0) ? g_src[0] : -1, 4);
        check("wd_src1", (g_src.size() > 1) ? g_src[1] : -1, 5);
        check("wd_release", (f_cyc.size() > 0) ? f_cyc[0] - t0 : -1, 10);
        check("wd_regrant", (g_cyc.size() > 1) ? g_cyc[1] - t0 : -1, 11);
        check("wd_err", 64'(err_timeout[6]), 64'd1);
        check("wd_rr", dbg_rr_ptr[6*SW +: SW], 6);
        stall[4] = 0; drive_inputs();
        repeat (4) sync();
        check("orphan_ready", 64'(in_ready[4]), 64'd0);
        check("orphan_busy", 64'(out_busy[6]), 64'd0);
        check("wd_err_sticky", 64'(err_timeout[6]), 64'd1);
        qw[4].delete(); drive_inputs();

        // reset during beat 2 of a 5-beat packet
        clear_logs();
        sync();
        push_pkt(2, 3, 5); drive_inputs();
        sync();
        sync();
        rst = 1'b0;
        model_reset();
        for (int q = 0; q < NQ; q++) begin qw[q].delete(); stall[q] = 0; end
        drive_inputs();
        #1;
        check("rst_ready", 64'(in_ready), 64'd0);
        check("rst_wr", 64'(out_wr), 64'd0);
        check("rst_busy", 64'(out_busy), 64'd0);
        check("rst_sel", out_sel, 64'd0);
        check("rst_err", 64'(err_timeout), 64'd0);
        sync();
        sync();
        rst = 1'b1;
        sync();
        clear_logs();
        sync(); t0 = cyc;
        push_pkt(2, 3, 2); drive_inputs();
        wait_done(50);
        check("post_rst_src", (g_src.size() > 0) ? g_src[0] : -1, 2);
        check("post_rst_lat", (g_cyc.size() > 0) ? g_cyc[0] - t0 : -1, 1);
        check("post_rst_rr", dbg_rr_ptr[3*SW +: SW], 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL global_timeout: got running expected finished (cycle %0d)", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
